// File: rtl/eth_frame_builder.sv
// Ethernet II TX framer: prepends dst/src MAC and ethertype to a payload
// stream and zero-pads short payloads to the minimum length.
package eth_pkg;
  typedef logic [7:0] byte_t;
endpackage

module eth_frame_builder
  import eth_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE   = 16'h0800,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter int          MIN_PAYLOAD = 46
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] dst_mac,
  input  logic        pl_valid,
  input  byte_t       pl_data,
  input  logic        pl_eof,
  input  logic        pl_err,
  output logic        pl_ready,
  output logic        tx_valid,
  output byte_t       tx_data,
  output logic        tx_eof,
  output logic        tx_err,
  input  logic        tx_ready,
  output logic        tx_busy
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PAD
  } state_t;

  localparam logic [6:0] MIN_P = 7'(MIN_PAYLOAD);

  state_t      state, state_n;
  logic [3:0]  hdr_cnt, hdr_n;
  logic [5:0]  pl_cnt, pl_n;
  logic [47:0] dst_q, dst_n;
  logic        v_n, e_n, r_n;
  byte_t       d_n;

  logic             out_free;
  logic [0:13][7:0] hdr;
  logic [6:0]       pl_nxt;
  logic [5:0]       pl_inc;

  assign out_free = !tx_valid || tx_ready;
  assign pl_ready = (state == PAYLOAD) && out_free;
  assign tx_busy  = (state != IDLE);
  assign hdr      = {dst_q, SRC_MAC, ETHERTYPE};
  assign pl_nxt   = {1'b0, pl_cnt} + 7'd1;
  assign pl_inc   = (pl_nxt > MIN_P) ? pl_cnt : pl_nxt[5:0];

  always_comb begin
    state_n = state;
    hdr_n   = hdr_cnt;
    pl_n    = pl_cnt;
    dst_n   = dst_q;
    v_n     = tx_valid;
    d_n     = tx_data;
    e_n     = tx_eof;
    r_n     = tx_err;
    if (out_free) begin
      v_n = 1'b0;
      e_n = 1'b0;
      r_n = 1'b0;
      unique case (state)
        IDLE: begin
          if (pl_valid) begin
            dst_n   = dst_mac;
            v_n     = 1'b1;
            d_n     = dst_mac[47:40];
            hdr_n   = 4'd1;
            state_n = HEADER;
          end
        end
        HEADER: begin
          v_n = 1'b1;
          d_n = hdr[hdr_cnt];
          if (hdr_cnt == 4'd13) begin
            hdr_n   = 4'd0;
            pl_n    = 6'd0;
            state_n = PAYLOAD;
          end else begin
            hdr_n = hdr_cnt + 4'd1;
          end
        end
        PAYLOAD: begin
          if (pl_valid) begin
            v_n  = 1'b1;
            d_n  = pl_data;
            pl_n = pl_inc;
            if (pl_eof) begin
              if (pl_err) begin
                e_n     = 1'b1;
                r_n     = 1'b1;
                state_n = IDLE;
              end else if (pl_nxt >= MIN_P) begin
                e_n     = 1'b1;
                state_n = IDLE;
              end else begin
                state_n = PAD;
              end
            end
          end
        end
        PAD: begin
          v_n  = 1'b1;
          d_n  = 8'h00;
          pl_n = pl_inc;
          if (pl_nxt >= MIN_P) begin
            e_n     = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hdr_cnt  <= 4'd0;
      pl_cnt   <= 6'd0;
      dst_q    <= 48'd0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      tx_eof   <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      state    <= state_n;
      hdr_cnt  <= hdr_n;
      pl_cnt   <= pl_n;
      dst_q    <= dst_n;
      tx_valid <= v_n;
      tx_data  <= d_n;
      tx_eof   <= e_n;
      tx_err   <= r_n;
    end
  end

endmodule

// File: doc/eth_frame_builder.md
# eth_frame_builder

Transmit-side Ethernet framer. It takes a payload byte stream from the upper layer (IPv4/UDP builder) and prepends a 14-byte Ethernet II header: destination MAC, source MAC, then ethertype. It zero-pads short payloads to the 46-byte minimum and drives a byte-wide valid/ready stream into the MAC TX path. FCS and preamble are appended downstream by the MAC.

## Interface
Parameters:
- ETHERTYPE, 16'h0800: ethertype inserted at header bytes 12–13, MSB first.
- SRC_MAC, 48'h02_00_00_00_00_01: source MAC inserted at header bytes 6–11, MSB first.
- MIN_PAYLOAD, 46: minimum payload byte count; shorter frames are zero-padded up to this count.

Ports (all synchronous to clk):
- clk, input, 1: sole clock.
- rst_n, input, 1: asynchronous, active-low reset.
- dst_mac, input, 48: destination MAC; sampled once per frame, at frame start.
- pl_valid, input, 1: payload byte available.
- pl_data, input, 8 (byte_t): payload byte.
- pl_eof, input, 1: marks the last payload byte.
- pl_err, input, 1: abort flag; qualified only together with pl_eof.
- pl_ready, output, 1: payload byte accepted this cycle when pl_valid && pl_ready.
- tx_valid, output, 1: tx_data is valid.
- tx_data, output, 8 (byte_t): frame byte.
- tx_eof, output, 1: marks the last byte of the frame.
- tx_err, output, 1: frame aborted; asserted only together with tx_eof.
- tx_ready, input, 1: downstream accepts the byte when tx_valid && tx_ready.
- tx_busy, output, 1: high while state is not IDLE.

## Operation
- Output register: tx_valid, tx_data, tx_eof and tx_err are registered.
- Define out_free = !tx_valid || tx_ready. The output register loads only when out_free.
- When out_free and nothing is emitted, tx_valid clears to 0.
- tx_data, tx_eof and tx_err hold their values while tx_valid && !tx_ready.
- pl_ready = (state == PAYLOAD) && out_free. This is combinational from tx_ready and state. It is 0 in every other state.
- Counters: hdr_cnt is 4 bits (0–13). pl_cnt is 6 bits and saturates at MIN_PAYLOAD.
- State IDLE:
  - Waits for pl_valid && out_free.
  - Then it latches dst_mac, emits header byte 0 (dst_mac[47:40]), sets hdr_cnt = 1 and goes to HEADER.
  - No payload byte is consumed in IDLE.
- State HEADER:
  - Each out_free cycle emits header[hdr_cnt] and increments hdr_cnt.
  - Bytes 0–5 are the latched dst_mac, 6–11 are SRC_MAC, 12–13 are ETHERTYPE, all MSB first.
  - After emitting byte 13, pl_cnt clears to 0 and the state goes to PAYLOAD.
- State PAYLOAD: each accepted byte is copied to tx_data with tx_valid = 1, and pl_cnt increments (saturating). On the byte carrying pl_eof:
  - If pl_err: emit the byte with tx_eof = 1 and tx_err = 1, skip padding, go to IDLE.
  - Else if pl_cnt + 1 >= MIN_PAYLOAD: emit the byte with tx_eof = 1, go to IDLE.
  - Else: emit the byte with tx_eof = 0, go to PAD.
- State PAD:
  - Each out_free cycle emits 8'h00 and increments pl_cnt.
  - The byte that brings pl_cnt to MIN_PAYLOAD carries tx_eof = 1; the state then returns to IDLE.
- The upstream guarantees at least 1 payload byte per frame and an MTU of at most 1500 bytes. No upper length check is performed here.
- pl_err without pl_eof is ignored.
- Reset: the async assert clears everything.
  - Outputs: tx_valid = 0, tx_data = 8'h00, tx_eof = 0, tx_err = 0, tx_busy = 0, pl_ready = 0.
  - Internal: state = IDLE, hdr_cnt = 0, pl_cnt = 0.
  - A frame in flight at reset is truncated with no tx_eof; downstream drops it.

## Timing
- Start latency: pl_valid first high in IDLE at cycle N (with out_free) gives tx_valid = 1 carrying header byte 0 at N+1.
- With tx_ready held high:
  - Header bytes stream at 1 byte per cycle.
  - pl_ready rises in the cycle after header byte 13 is registered, so there is no bubble between header and payload.
  - Padding streams at 1 byte per cycle.
- Back-to-back frames: IDLE costs 0 extra cycles. The cycle after tx_eof is registered, IDLE can already load header byte 0 if pl_valid.
- Frame length is 14 + max(payload length, 46) bytes on tx; for example, a 1-byte payload gives 60 bytes.
- Backpressure: while tx_ready = 0 with tx_valid = 1:
  - All state, counters and outputs hold.
  - pl_ready = 0.
  - Source bytes are not lost.
- dst_mac may change mid-frame without effect. The new value is used only at the next frame start.

## Test plan
- Basic frame: dst_mac = 48'hFFFF_FFFF_FFFF, 46-byte payload 0x00..0x2D, tx_ready = 1. Required:
  - 60 tx bytes: FF×6, 02 00 00 00 00 01, 08 00, then 00..2D.
  - tx_eof on byte 59 only.
  - tx_valid contiguous from the cycle after pl_valid.
- Short-frame padding: a 1-byte payload 0xAB gives 60 tx bytes. Byte 14 = AB, bytes 15–59 = 00, tx_eof on byte 59.
- Abort: a 10-byte payload with pl_err && pl_eof on the last byte. Required:
  - 24 tx bytes.
  - tx_eof and tx_err both on byte 23.
  - No padding; tx_err is never high elsewhere.
- Backpressure: random tx_ready (about 50% duty) on a 100-byte payload.
  - Output is byte-identical to the tx_ready = 1 run.
  - tx_data is stable while stalled.
  - pl_ready is never high while tx_valid && !tx_ready.
- Back-to-back and mid-frame dst_mac change: two frames sent with no gap, and dst_mac changed during frame 1's payload. Required: frame 1 keeps its original MAC, and frame 2's header byte 0 follows frame 1's eof by 1 cycle.
- Reset mid-frame: assert rst_n = 0 at header byte 8. Required:
  - All outputs go to 0 immediately.
  - After release, the next frame is complete and correct.
